// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and address helpers for the banked SRAM loader
package sram_pkg;

    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // Linear address = {bank, row}; aw is the row-field width.
    function automatic int unsigned bank_of(input int unsigned caddr, input int unsigned aw);
        return caddr >> aw;
    endfunction

    function automatic int unsigned row_of(input int unsigned caddr, input int unsigned aw);
        return caddr & ((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - one SRAM bank: single write port, registered read port with write-first bypass
module sram_bank #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= re;
            if (re) begin
                q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sram_nblk_loader.sv
// rtl/sram_nblk_loader.sv - NBLK-bank SRAM with shared write port and streaming load sequencer
module sram_nblk_loader
    import sram_pkg::*;
#(
    parameter  int NBLK  = 8,
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 20,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = $clog2(NBLK),
    localparam int CAW   = AW + BW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen_n,
    input  logic                  wen_n,
    input  logic [CAW-1:0]        caddr,
    input  logic [WIDTH-1:0]      d,
    input  logic [NBLK-1:0]       rd_en,
    input  logic [NBLK*AW-1:0]    a,
    output logic [NBLK*WIDTH-1:0] q,
    output logic [NBLK-1:0]       q_valid,
    input  logic                  ld_start,
    input  logic [CAW-1:0]        ld_base,
    input  logic [CAW:0]          ld_len,
    input  logic                  ld_valid,
    input  logic [WIDTH-1:0]      ld_data,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done
);

    localparam logic [CAW-1:0] PTR_LAST = CAW'(NBLK * DEPTH - 1);

    ld_state_t        state;
    ld_state_t        state_nxt;
    logic [CAW-1:0]   ptr;
    logic [CAW:0]     cnt;
    logic [CAW:0]     len;

    logic             dir_we;
    logic             ld_acc;
    logic             wr_en;
    logic [CAW-1:0]   wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [BW-1:0]    wr_bank;
    logic [AW-1:0]    wr_row;
    logic [NBLK-1:0]  bank_we;

    assign dir_we = (cen_n == ON) && (wen_n == ON);
    assign ld_acc = ld_valid && ld_ready;

    // Direct writes and loader beats never coincide: ld_ready drops whenever wen_n is active.
    always_comb begin
        wr_en   = dir_we || ld_acc;
        wr_addr = dir_we ? caddr : ptr;
        wr_data = dir_we ? d : ld_data;
    end

    assign wr_bank = BW'(bank_of(32'(wr_addr), AW));
    assign wr_row  = AW'(row_of(32'(wr_addr), AW));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nxt = (ld_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ld_acc && ((cnt + (CAW+1)'(1)) == len)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        ld_done  = 1'b0;
        case (state)
            LOAD: begin
                ld_busy  = 1'b1;
                ld_ready = (cen_n == ON) && (wen_n == OFF);
            end
            DONE:    ld_done = 1'b1;
            default: ;
        endcase
    end

    // ld_acc already implies cen_n active, so the counters freeze with the chip disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
            len <= '0;
        end else if ((state == IDLE) && ld_start && (ld_len != '0)) begin
            ptr <= ld_base;
            cnt <= '0;
            len <= ld_len;
        end else if (ld_acc) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + CAW'(1);
            cnt <= cnt + (CAW+1)'(1);
        end
    end

    for (genvar b = 0; b < NBLK; b++) begin : g_bank
        assign bank_we[b] = wr_en && (wr_bank == BW'(b));

        sram_bank #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (bank_we[b]),
            .waddr   (wr_row),
            .wdata   (wr_data),
            .re      ((cen_n == ON) && rd_en[b]),
            .raddr   (a[b*AW +: AW]),
            .q       (q[b*WIDTH +: WIDTH]),
            .q_valid (q_valid[b])
        );
    end

endmodule

// File: tb/tb_sram_nblk_loader.sv
// tb/tb_sram_nblk_loader.sv - directed self-checking bench with a word-level memory/loader model
module tb_sram_nblk_loader;

    logic         clk = 1'b0;
    logic         rst_n, cen_n, wen_n;
    logic [10:0]  caddr;
    logic [19:0]  d;
    logic [7:0]   rd_en;
    logic [63:0]  a;
    wire  [159:0] q;
    wire  [7:0]   q_valid;
    logic         ld_start, ld_valid;
    logic [10:0]  ld_base;
    logic [11:0]  ld_len;
    logic [19:0]  ld_data;
    wire          ld_ready, ld_busy, ld_done;

    sram_nblk_loader dut (
        .clk(clk), .rst_n(rst_n), .cen_n(cen_n), .wen_n(wen_n), .caddr(caddr), .d(d),
        .rd_en(rd_en), .a(a), .q(q), .q_valid(q_valid),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // Model: flat 2048-word memory plus an abstract "words remaining" loader.
    logic [19:0] mmem [2048];
    bit          mknown [2048];
    logic [19:0] eq [8];
    bit          eqk [8];
    logic [7:0]  eqv = '0;
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_ptr = 0;
    int          m_left = 0;
    bit          m_wr, m_ready;
    int          m_wa, m_ra;
    logic [19:0] m_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            eqv = '0;
            for (int b = 0; b < 8; b++) begin
                eq[b] = '0;
                eqk[b] = 1;
            end
            m_active = 0;
            m_done = 0;
        end else begin
            m_ready = m_active && !cen_n && wen_n;
            m_wr = 0;
            if (!cen_n && !wen_n) begin
                m_wr = 1; m_wa = int'(caddr); m_wd = d;
            end else if (m_ready && ld_valid) begin
                m_wr = 1; m_wa = m_ptr; m_wd = ld_data;
            end
            for (int b = 0; b < 8; b++) begin
                if (!cen_n && rd_en[b]) begin
                    m_ra = b * 256 + int'(a[b*8 +: 8]);
                    eqv[b] = 1'b1;
                    if (m_wr && m_wa == m_ra) begin
                        eq[b] = m_wd; eqk[b] = 1;
                    end else begin
                        eq[b] = mmem[m_ra]; eqk[b] = mknown[m_ra];
                    end
                end else begin
                    eqv[b] = 1'b0;
                end
            end
            if (m_wr) begin
                mmem[m_wa] = m_wd;
                mknown[m_wa] = 1;
            end
            if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (ld_start) begin
                    if (ld_len == 0) m_done = 1;
                    else begin
                        m_active = 1; m_ptr = int'(ld_base); m_left = int'(ld_len);
                    end
                end
            end else if (m_ready && ld_valid) begin
                m_ptr = (m_ptr + 1) % 2048;
                m_left--;
                if (m_left == 0) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q_valid", 32'(q_valid), 32'(eqv));
            for (int b = 0; b < 8; b++) begin
                if (eqk[b]) chk($sformatf("q%0d", b), 32'(q[b*20 +: 20]), 32'(eq[b]));
            end
            chk("ld_ready", 32'(ld_ready), 32'(m_active && !cen_n && wen_n));
            chk("ld_busy", 32'(ld_busy), 32'(m_active));
            chk("ld_done", 32'(ld_done), 32'(m_done));
            if (ld_done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int addr, input logic [19:0] exp, input string nm);
        int bk;
        bk = addr / 256;
        rd_en = 8'(1 << bk);
        a[bk*8 +: 8] = 8'(addr % 256);
        step();
        rd_en = '0;
        @(negedge clk);
        chk(nm, 32'(q[bk*20 +: 20]), 32'(exp));
    endtask

    initial begin
        int n;
        rst_n = 0; cen_n = 1; wen_n = 1; caddr = '0; d = '0; rd_en = '0; a = '0;
        ld_start = 0; ld_base = '0; ld_len = '0; ld_valid = 0; ld_data = '0;
        for (int i = 0; i < 2048; i++) mknown[i] = 0;
        step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_q0", 32'(q[19:0]), 32'h0);
        chk("rst_busy", 32'({ld_ready, ld_busy, ld_done}), 32'h0);
        rst_n = 1; cen_n = 0;

        // Direct fill: each row k holds k in every bank
        wen_n = 0;
        for (int i = 0; i < 2048; i++) begin
            caddr = 11'(i); d = 20'(i % 256);
            step();
        end
        wen_n = 1;
        for (int k = 0; k < 256; k++) begin
            rd_en = 8'hFF;
            a = {8{8'(k)}};
            step();
            rd_en = '0;
            if (k == 200) begin
                @(negedge clk);
                chk("fill_q7_row200", 32'(q[7*20 +: 20]), 32'd200);
                chk("fill_qv_all", 32'(q_valid), 32'hFF);
            end
            step();
        end

        // Write-first bypass
        wen_n = 0; caddr = 11'h305; d = 20'hABCDE;
        rd_en = 8'h0C; a[3*8 +: 8] = 8'h05; a[2*8 +: 8] = 8'h05;
        step();
        wen_n = 1; rd_en = '0;
        @(negedge clk);
        chk("bypass_q3", 32'(q[3*20 +: 20]), 32'hABCDE);
        chk("bypass_q2", 32'(q[2*20 +: 20]), 32'h5);

        // Stream load wrapping past the top address, with valid gaps
        done_cnt = 0;
        ld_base = 11'd2046; ld_len = 12'd4; ld_start = 1;
        step();
        ld_start = 0;
        n = 1;
        for (int i = 0; n <= 4; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data = 20'(n);
            step();
            if (ld_valid) n++;
        end
        ld_valid = 0;
        @(negedge clk);
        chk("wrap_done_pulse", 32'(ld_done), 32'h1);
        step();
        @(negedge clk);
        chk("wrap_done_clear", 32'(ld_done), 32'h0);
        chk("wrap_done_count", 32'(done_cnt), 32'd1);
        read_chk(2046, 20'd1, "wrap_2046");
        read_chk(2047, 20'd2, "wrap_2047");
        read_chk(0, 20'd3, "wrap_0");
        read_chk(1, 20'd4, "wrap_1");

        // Direct writes collide with the loader and win
        ld_base = 11'd100; ld_len = 12'd4; ld_start = 1;
        step();
        ld_start = 0;
        ld_valid = 1; ld_data = 20'h100;
        step();
        ld_data = 20'h101; wen_n = 0; caddr = 11'd500; d = 20'h5A5;
        @(negedge clk);
        chk("coll_ready0_a", 32'(ld_ready), 32'h0);
        step();
        caddr = 11'd501; d = 20'h5A6;
        @(negedge clk);
        chk("coll_ready0_b", 32'(ld_ready), 32'h0);
        step();
        wen_n = 1;
        step();
        ld_data = 20'h102;
        step();
        ld_data = 20'h103;
        step();
        ld_valid = 0;
        step();
        read_chk(101, 20'h101, "coll_101");
        read_chk(103, 20'h103, "coll_103");
        read_chk(500, 20'h5A5, "coll_500");
        read_chk(501, 20'h5A6, "coll_501");

        // Reset in the middle of a load
        ld_base = 11'd300; ld_len = 12'd10; ld_start = 1;
        step();
        ld_start = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = 20'(8'h11 + i);
            step();
        end
        ld_valid = 0; rst_n = 0;
        step();
        @(negedge clk);
        chk("rstmid_flags", 32'({ld_ready, ld_busy, ld_done}), 32'h0);
        chk("rstmid_q_valid", 32'(q_valid), 32'h0);
        chk("rstmid_q1", 32'(q[1*20 +: 20]), 32'h0);
        rst_n = 1;
        step();
        read_chk(300, 20'h11, "rstmid_300");
        read_chk(302, 20'h13, "rstmid_302");
        read_chk(303, 20'h2F, "rstmid_303");

        // Zero-length load finishes immediately
        ld_len = 12'd0; ld_start = 1;
        step();
        ld_start = 0;
        @(negedge clk);
        chk("len0_done", 32'(ld_done), 32'h1);
        chk("len0_busy", 32'(ld_busy), 32'h0);
        step();
        @(negedge clk);
        chk("len0_done_clear", 32'(ld_done), 32'h0);

        // Chip disabled during a load: no progress, no reads
        ld_base = 11'd600; ld_len = 12'd2; ld_start = 1;
        step();
        ld_start = 0;
        cen_n = 1; ld_valid = 1; ld_data = 20'h999; rd_en = 8'hFF;
        @(negedge clk);
        chk("cen_ready0", 32'(ld_ready), 32'h0);
        step();
        step();
        @(negedge clk);
        chk("cen_qv0", 32'(q_valid), 32'h0);
        chk("cen_busy", 32'(ld_busy), 32'h1);
        cen_n = 0; rd_en = '0; ld_data = 20'h777;
        step();
        ld_data = 20'h778;
        step();
        ld_valid = 0;
        step();
        read_chk(600, 20'h777, "cen_600");
        read_chk(601, 20'h778, "cen_601");
        read_chk(602, 20'h5A, "cen_602");

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
